// File: rtl/mem_seq_pkg.sv
// ============================================================================
// Module : mem_seq_pkg
// Brief  : Shared encodings and alignment helper for the memory access sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_seq_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // The reserved size code behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return (size != SZ_HALF) && (size != SZ_BYTE);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = lane[0];
      default: m = (lane != 2'b00);
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_merge.sv
// ============================================================================
// Module : byte_lane_merge
// Brief  : Little-endian lane insert (store merge) and lane extract (load).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module byte_lane_merge
  import mem_seq_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  always_comb begin
    merged    = old_word;
    extracted = old_word;
    case (size)
      SZ_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        extracted = {24'd0, old_word[{lane, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        extracted = {16'd0, old_word[{lane[1], 4'b0000} +: 16]};
      end
      default: begin
        merged    = wdata;
        extracted = old_word;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_seq.sv
// ============================================================================
// Module : mem_access_seq
// Brief  : Multicycle load/store sequencer (read, write, read-modify-write).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int              CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       merged_w, extracted_w;

  byte_lane_merge u_merge (
    .old_word  (mem_rdata),
    .wdata     (wdata_q),
    .size      (size_q),
    .lane      (lane_q),
    .merged    (merged_w),
    .extracted (extracted_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_WORD;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          lane_d     = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = {addr[31:2], 2'b00};
          cnt_d      = '0;
          err_d      = misaligned(size, addr[1:0]);
          if (misaligned(size, addr[1:0])) begin
            state_d = ST_DONE;
          end else if (we && is_word(size)) begin
            mem_wdata_d = wdata;
            state_d     = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        // Read data is sampled only on the edge closing the final wait cycle.
        if (cnt_q == CNT_LAST) begin
          if (we_q) begin
            mem_wdata_d = merged_w;
            state_d     = ST_WR;
          end else begin
            rdata_d = extracted_w;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WR:   state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign mem_wr    = (state_q == ST_WR);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_seq.sv
// ============================================================================
// Module : tb_mem_access_seq
// Brief  : Self-checking bench: directed table, corner sequences, random vs model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_seq;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, err, mem_wr;

  logic [31:0] memw [0:255];
  logic [7:0]  refb [0:1023];

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_hold;

  always #5 clk = ~clk;

  mem_access_seq #(.READ_LAT(RL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Word-wide RAM seen by the DUT: asynchronous read, write on the clock edge.
  assign mem_rdata = memw[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_wr) memw[mem_addr[9:2]] = mem_wdata;
  end

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_word;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one request from a negedge and watch it to completion.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input int exp_wr,
                         input string nm);
    int done_at, wr_cnt, stray_err;
    logic busy_ok, err_at_done;
    we = w; size = sz; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    done_at = -1; wr_cnt = 0; stray_err = 0; busy_ok = 1'b1; err_at_done = 1'b0;
    for (int k = 0; k < 16 && done_at < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req = 1'b0;
        check({nm, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
      end
      if (mem_wr) wr_cnt++;
      if (!busy) busy_ok = 1'b0;
      if (err && !done) stray_err++;
      if (done) begin
        done_at = k;
        err_at_done = err;
      end
    end
    check({nm, "_latency"}, done_at, exp_lat);
    check({nm, "_err"}, {31'd0, err_at_done}, {31'd0, exp_err});
    check({nm, "_writes"}, wr_cnt, exp_wr);
    check({nm, "_busy_stray_err"}, {busy_ok, stray_err[30:0]}, 32'h8000_0000);
    check({nm, "_rdata"}, rdata, exp_rd);
    @(negedge clk);
    check({nm, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  vec_t tbl [11];

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) memw[i] = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {28'd0, busy, done, err, mem_wr}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table; each entry starts from mem[0x40] = 0xDEADBEEF.
    tbl[0]  = '{1'b0, 2'b00, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0, RL,   0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 2'b10, 32'h42, 32'h000000AA, 32'hDEADBEEF, 1'b0, RL+1, 1, 32'hDEAABEEF};
    tbl[2]  = '{1'b0, 2'b01, 32'h42, 32'h0,        32'h0000DEAD, 1'b0, RL,   0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 2'b00, 32'h41, 32'h0,        32'h0000DEAD, 1'b1, 0,    0, 32'hDEADBEEF};
    tbl[4]  = '{1'b0, 2'b10, 32'h43, 32'h0,        32'h000000DE, 1'b0, RL,   0, 32'hDEADBEEF};
    tbl[5]  = '{1'b1, 2'b01, 32'h40, 32'hFFFF1234, 32'h000000DE, 1'b0, RL+1, 1, 32'hDEAD1234};
    tbl[6]  = '{1'b1, 2'b00, 32'h40, 32'hCAFEF00D, 32'h000000DE, 1'b0, 1,    1, 32'hCAFEF00D};
    tbl[7]  = '{1'b1, 2'b01, 32'h43, 32'h00001111, 32'h000000DE, 1'b1, 0,    0, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 2'b11, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0, RL,   0, 32'hDEADBEEF};
    tbl[9]  = '{1'b1, 2'b10, 32'h41, 32'hFFFFFF55, 32'hDEADBEEF, 1'b0, RL+1, 1, 32'hDEAD55EF};
    tbl[10] = '{1'b0, 2'b10, 32'h40, 32'h0,        32'h000000EF, 1'b0, RL,   0, 32'hDEADBEEF};
    for (int i = 0; i < 11; i++) begin
      memw[16] = 32'hDEADBEEF;
      run_txn(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_err,
              tbl[i].exp_lat, tbl[i].exp_wr, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_word", i), memw[16], tbl[i].exp_word);
    end
    exp_hold = 32'h000000EF;

    // Back-to-back word stores with req held high throughout.
    begin
      logic [8:0] wr_pat, done_pat;
      wr_pat = '0; done_pat = '0;
      we = 1'b1; size = 2'b00; addr = 32'h80; wdata = 32'h11111111; req = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        wr_pat[k] = mem_wr;
        done_pat[k] = done;
        if (k == 1) begin addr = 32'h84; wdata = 32'h22222222; end
        if (k == 4) begin addr = 32'h88; wdata = 32'h33333333; end
        if (k == 8) req = 1'b0;
      end
      check("b2b_wr_pattern", {23'd0, wr_pat}, 32'b001001001);
      check("b2b_done_pattern", {23'd0, done_pat}, 32'b010010010);
      check("b2b_word0", memw[32], 32'h11111111);
      check("b2b_word1", memw[33], 32'h22222222);
      check("b2b_word2", memw[34], 32'h33333333);
      @(negedge clk);
      check("b2b_idle", {30'd0, busy, done}, 32'd0);
    end

    // Reset while a sub-word store is still reading.
    begin
      int stray;
      memw[16] = 32'hDEADBEEF;
      we = 1'b1; size = 2'b10; addr = 32'h42; wdata = 32'h000000AA; req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("midrst_ctrl", {28'd0, busy, done, err, mem_wr}, 32'd0);
      check("midrst_addr_wdata", mem_addr | mem_wdata | rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      stray = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done || mem_wr) stray++;
      end
      check("midrst_no_activity", stray, 0);
      check("midrst_word", memw[16], 32'hDEADBEEF);
      run_txn(1'b0, 2'b10, 32'h42, 32'h0, 32'h000000AD, 1'b0, RL, 0, "post_rst_load");
      exp_hold = 32'h000000AD;
    end

    // Random traffic against a byte-addressed reference memory.
    for (int i = 0; i < 256; i++) begin
      memw[i] = $urandom;
      for (int b = 0; b < 4; b++) refb[4*i+b] = memw[i][8*b +: 8];
    end
    for (int t = 0; t < 60; t++) begin
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a, wd, rd;
      int          nb, lat, nw;
      logic        mis;
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 1023);
      wd = $urandom;
      nb = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
      if ($urandom_range(0, 3) != 0) a = a - (a % nb);
      mis = (a % nb) != 0;
      lat = 0; nw = 0;
      if (!mis) begin
        if (w) begin
          for (int b = 0; b < nb; b++) refb[a+b] = wd[8*b +: 8];
          lat = (nb == 4) ? 1 : RL + 1;
          nw = 1;
        end else begin
          rd = 32'd0;
          for (int b = 0; b < nb; b++) rd = rd | (32'(refb[a+b]) << (8*b));
          exp_hold = rd;
          lat = RL;
        end
      end
      run_txn(w, sz, a, wd, exp_hold, mis, lat, nw, $sformatf("rnd%0d", t));
    end
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (memw[i] !== {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]}) bad++;
      check("rnd_mem_final_bad_words", bad, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
